// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: signal bundle between the CPU ports, the arbiter and the block RAM.
//   i_*   : instruction-fetch request/ack/read-data
//   d_*   : load/store request/ack/write-data/byte-mask/read-data
//   mem_* : single-port RAM address, write data, read/write select (1 = read), read data
// Modports:
//   slave  : the arbiter side
//   master : the environment side (CPU requesters plus memory)
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [31:0]       i_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [3:0]        d_wmask;
    logic              d_ack;
    logic [31:0]       d_rdata;

    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_rw;
    logic [31:0]       mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wmask, mem_rdata,
        output i_ack, i_rdata, d_ack, d_rdata, mem_addr, mem_wdata, mem_rw
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wmask, mem_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata, mem_addr, mem_wdata, mem_rw
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port 256x32 RAM between the instruction-fetch port and the
// load/store port. One requester is granted at a time; on a tie the port not granted last
// time wins. Byte/halfword stores are done as read-modify-write since the RAM has no byte
// enables.
// Ports:
//   clk    : rising-edge clock, shared with the RAM
//   resetn : asynchronous active-low reset
//   bus    : mem_arbiter_if.slave (fetch port, load/store port, RAM side)
module mem_arbiter #(
    parameter int unsigned ADDR_W = 32
) (
    input logic            clk,
    input logic            resetn,
    mem_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {StIdle, StRd, StRmw, StWack} state_e;

    state_e            state_q, state_d;
    logic              gnt_d_q, gnt_d_d;   // 1 = data port owns the current transaction
    logic              last_d_q, last_d_d; // 1 = data port was granted last
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wmask_q, wmask_d;
    logic [31:0]       i_rdata_q, i_rdata_d;
    logic [31:0]       d_rdata_q, d_rdata_d;

    logic              any_req;
    logic              pick_d;
    logic [31:0]       merged;

    always_comb begin
        // Never grant while reset is asserted, so a held request cannot write the RAM.
        any_req = resetn && (bus.i_req || bus.d_req);
        pick_d  = bus.d_req && (!bus.i_req || !last_d_q);
        for (int n = 0; n < 4; n++) begin
            merged[8*n +: 8] = wmask_q[n] ? wdata_q[8*n +: 8] : bus.mem_rdata[8*n +: 8];
        end
    end

    always_comb begin
        state_d       = state_q;
        gnt_d_d       = gnt_d_q;
        last_d_d      = last_d_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wmask_d       = wmask_q;
        i_rdata_d     = i_rdata_q;
        d_rdata_d     = d_rdata_q;
        bus.mem_addr  = 32'(addr_q);
        bus.mem_wdata = wdata_q;
        bus.mem_rw    = 1'b1;
        bus.i_ack     = 1'b0;
        bus.d_ack     = 1'b0;
        bus.i_rdata   = i_rdata_q;
        bus.d_rdata   = d_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    gnt_d_d  = pick_d;
                    last_d_d = pick_d;
                    addr_d   = pick_d ? bus.d_addr : bus.i_addr;
                    if (pick_d) begin
                        wdata_d = bus.d_wdata;
                        wmask_d = bus.d_wmask;
                    end
                    // First access uses the live address; later states use the captured one.
                    bus.mem_addr = 32'(addr_d);
                    if (!pick_d || !bus.d_we) begin
                        state_d = StRd;
                    end else if (bus.d_wmask == 4'b1111) begin
                        bus.mem_rw    = 1'b0;
                        bus.mem_wdata = bus.d_wdata;
                        state_d       = StWack;
                    end else if (bus.d_wmask == 4'b0000) begin
                        state_d = StWack;
                    end else begin
                        // Read half of read-modify-write; mem_rw stays 1.
                        state_d = StRmw;
                    end
                end
            end
            StRd: begin
                if (gnt_d_q) begin
                    bus.d_ack   = 1'b1;
                    bus.d_rdata = bus.mem_rdata;
                    d_rdata_d   = bus.mem_rdata;
                end else begin
                    bus.i_ack   = 1'b1;
                    bus.i_rdata = bus.mem_rdata;
                    i_rdata_d   = bus.mem_rdata;
                end
                state_d = StIdle;
            end
            StRmw: begin
                bus.mem_rw    = 1'b0;
                bus.mem_wdata = merged;
                state_d       = StWack;
            end
            StWack: begin
                bus.d_ack = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            gnt_d_q   <= 1'b0;
            last_d_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            gnt_d_q   <= gnt_d_d;
            last_d_q  <= last_d_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wmask_q   <= wmask_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: bench for mem_arbiter with a behavioural 256x32 RAM, a directed vector
// table, hand-written multi-cycle sequences and randomized traffic against a byte-level model.
module tb_mem_arbiter;

    logic clk;
    logic resetn;

    mem_arbiter_if #(.ADDR_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM with registered read (old data on a simultaneous write) plus a write monitor.
    logic [31:0] ram [256];
    int          wr_cnt;
    logic [31:0] last_wr_data;
    initial wr_cnt = 0;

    always @(posedge clk) begin
        if (!bus.mem_rw) begin
            ram[bus.mem_addr[9:2]] <= bus.mem_wdata;
            wr_cnt                 <= wr_cnt + 1;
            last_wr_data           <= bus.mem_wdata;
        end
        bus.mem_rdata <= ram[bus.mem_addr[9:2]];
    end

    int checks;
    int failures;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one transaction on a single port and wait (bounded) for its ack.
    task automatic run_txn(input bit is_d, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] mask,
                           output logic [31:0] rd, output int lat, output int nwr,
                           output logic [31:0] wd);
        int w0;
        @(negedge clk);
        w0 = wr_cnt;
        if (is_d) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr;
            bus.d_wdata = wdata; bus.d_wmask = mask;
        end else begin
            bus.i_req = 1'b1; bus.i_addr = addr;
        end
        lat = -1;
        rd  = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (is_d ? bus.d_ack : bus.i_ack) begin
                lat = k;
                rd  = is_d ? bus.d_rdata : bus.i_rdata;
                break;
            end
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        nwr = wr_cnt - w0;
        wd  = last_wr_data;
    endtask

    task automatic do_reset();
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        int          exp_lat;
        int          exp_wr;
        bit          chk_rd;
        logic [31:0] exp_rd;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t        tbl [13];
    logic [7:0]  ref_bytes [1024];

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        int base;
        base = int'(a % 1024) - int'(a % 4);
        return {ref_bytes[base + 3], ref_bytes[base + 2], ref_bytes[base + 1], ref_bytes[base]};
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [31:0] wdata,
                             input logic [3:0] mask);
        int base;
        base = int'(a % 1024) - int'(a % 4);
        for (int n = 0; n < 4; n++) begin
            if (mask[n]) ref_bytes[base + n] = wdata[8*n +: 8];
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, wd, a, wdata;
        logic [3:0]  mask;
        int          lat, nwr, w0, exp_lat, exp_wr;
        bit          is_d, we;
        bit          order [$];

        checks   = 0;
        failures = 0;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0;
        bus.d_wdata = '0; bus.d_wmask = '0;
        resetn = 1'b0;

        tbl[0]  = '{1, 1, 32'h10, 32'hDEADBEEF, 4'hF, 1, 1, 0, 32'h0, 32'hDEADBEEF};
        tbl[1]  = '{0, 0, 32'h10, 32'h0,        4'h0, 1, 0, 1, 32'hDEADBEEF, 32'h0};
        tbl[2]  = '{1, 1, 32'h20, 32'h11223344, 4'hF, 1, 1, 0, 32'h0, 32'h11223344};
        tbl[3]  = '{1, 0, 32'h20, 32'h0,        4'h0, 1, 0, 1, 32'h11223344, 32'h0};
        tbl[4]  = '{1, 1, 32'h20, 32'hAABBCCDD, 4'hF, 1, 1, 0, 32'h0, 32'hAABBCCDD};
        tbl[5]  = '{1, 1, 32'h22, 32'h0000EE00, 4'h2, 2, 1, 0, 32'h0, 32'hAABBEEDD};
        tbl[6]  = '{1, 0, 32'h21, 32'h0,        4'h0, 1, 0, 1, 32'hAABBEEDD, 32'h0};
        tbl[7]  = '{1, 1, 32'h20, 32'hFFFFFFFF, 4'h0, 1, 0, 0, 32'h0, 32'h0};
        tbl[8]  = '{0, 0, 32'h23, 32'h0,        4'h0, 1, 0, 1, 32'hAABBEEDD, 32'h0};
        tbl[9]  = '{1, 1, 32'h40, 32'h00000000, 4'hF, 1, 1, 0, 32'h0, 32'h00000000};
        tbl[10] = '{1, 1, 32'h40, 32'h55667788, 4'hC, 2, 1, 0, 32'h0, 32'h55660000};
        tbl[11] = '{1, 0, 32'h40, 32'h0,        4'h0, 1, 0, 1, 32'h55660000, 32'h0};
        tbl[12] = '{1, 1, 32'h30, 32'h01020304, 4'hF, 1, 1, 0, 32'h0, 32'h01020304};

        // Reset values.
        repeat (2) @(negedge clk);
        chk("rst_mem_rw", 32'(bus.mem_rw), 32'h1);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_i_ack", 32'(bus.i_ack), 32'h0);
        chk("rst_d_ack", 32'(bus.d_ack), 32'h0);
        chk("rst_i_rdata", bus.i_rdata, 32'h0);
        chk("rst_d_rdata", bus.d_rdata, 32'h0);
        resetn = 1'b1;

        // Tie right after reset: data first, then strict alternation.
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_addr = 32'h0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h4;
        for (int k = 0; k < 12 && order.size() < 4; k++) begin
            @(negedge clk);
            if (bus.i_ack && bus.d_ack) chk("alt_both_ack", 32'h1, 32'h0);
            if (bus.d_ack) order.push_back(1'b1);
            if (bus.i_ack) order.push_back(1'b0);
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        chk("alt_count", 32'(order.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("alt_grant%0d_is_data", k),
                (k < order.size()) ? 32'(order[k]) : 32'hX, 32'((k % 2) == 0));
        end

        // Directed vector table.
        foreach (tbl[i]) begin
            run_txn(tbl[i].is_d, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].mask,
                    rd, lat, nwr, wd);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].exp_lat));
            chk($sformatf("vec%0d_writes", i), 32'(nwr), 32'(tbl[i].exp_wr));
            if (tbl[i].chk_rd) chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
            if (tbl[i].exp_wr == 1) chk($sformatf("vec%0d_wdata", i), wd, tbl[i].exp_wd);
        end

        // Read data holds after the ack cycle.
        run_txn(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, rd, lat, nwr, wd);
        @(negedge clk);
        chk("hold_d_ack", 32'(bus.d_ack), 32'h0);
        chk("hold_d_rdata", bus.d_rdata, 32'h55660000);
        chk("hold_i_rdata", bus.i_rdata, 32'hAABBEEDD);

        // Reset asserted during the RMW write cycle of a partial store.
        @(negedge clk);
        w0 = wr_cnt;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h30;
        bus.d_wdata = 32'h000000FF; bus.d_wmask = 4'b0001;
        @(posedge clk);
        #1;
        chk("rmw_cycle_mem_rw", 32'(bus.mem_rw), 32'h0);
        resetn = 1'b0;
        bus.d_req = 1'b0;
        #1;
        chk("rmw_rst_mem_rw", 32'(bus.mem_rw), 32'h1);
        chk("rmw_rst_d_ack", 32'(bus.d_ack), 32'h0);
        chk("rmw_rst_i_ack", 32'(bus.i_ack), 32'h0);
        chk("rmw_rst_mem_addr", bus.mem_addr, 32'h0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        chk("rmw_rst_writes", 32'(wr_cnt - w0), 32'h0);
        run_txn(1'b1, 1'b0, 32'h30, 32'h0, 4'h0, rd, lat, nwr, wd);
        chk("rmw_rst_reload", rd, 32'h01020304);

        // Randomized traffic against a byte-level memory model over words 0x100..0x13C.
        for (int w = 0; w < 16; w++) begin
            wdata = $urandom;
            a     = 32'h100 + 32'(w * 4);
            run_txn(1'b1, 1'b1, a, wdata, 4'hF, rd, lat, nwr, wd);
            ref_store(a, wdata, 4'hF);
        end
        for (int n = 0; n < 150; n++) begin
            is_d  = ($urandom_range(0, 2) != 0);
            we    = is_d && ($urandom_range(0, 1) == 1);
            a     = 32'h100 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
            wdata = $urandom;
            mask  = 4'($urandom_range(0, 15));
            run_txn(is_d, we, a, wdata, mask, rd, lat, nwr, wd);
            exp_lat = (we && mask != 4'h0 && mask != 4'hF) ? 2 : 1;
            exp_wr  = (we && mask != 4'h0) ? 1 : 0;
            chk($sformatf("rnd%0d_latency", n), 32'(lat), 32'(exp_lat));
            chk($sformatf("rnd%0d_writes", n), 32'(nwr), 32'(exp_wr));
            if (we) begin
                ref_store(a, wdata, mask);
                if (exp_wr == 1) chk($sformatf("rnd%0d_wdata", n), wd, ref_word(a));
            end else begin
                chk($sformatf("rnd%0d_rdata", n), rd, ref_word(a));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
